led_fade_pwm: RTL and testbench

- Sits directly downstream of the LED chaser pattern register on the MKR Vidor top.
- Consumes the per-LED on/off pattern and drives `mkr_gpio` LED pins with PWM.
- A lit LED snaps to full brightness. An LED whose pattern bit clears fades linearly to off, giving the chaser a visible trail.
- All state is in the single FPGA clock domain.

---
 rtl/led_fade_pwm.sv | 136 +++++++++++++
 tb/tb_led_fade_pwm.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_fade_pwm.sv
// led_fade_pwm
//   PWM driver for the LED chaser. A channel whose pattern bit is set jumps
//   to full brightness; once the bit clears, the channel's level decays by
//   DECAY_STEP every DECAY_DIV enabled cycles until it reaches zero, leaving
//   a fading trail behind the chaser.
//
// Ports
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   enable   1 = run; 0 = outputs forced off, PWM and decay frozen
//   pattern  per-LED request from the chaser (bit i = LED i on)
//   led_out  registered PWM drive to the GPIO pins
//   busy     registered; 1 while any channel level is nonzero
//
// Optional build macro
//   LED_FADE_GAMMA_EN  square-law duty mapping (duty = level^2 >> PWM_BITS)
//                      for a perceptually linear fade. Default build uses
//                      duty = level and has no multiplier.

module led_fade_pwm #(
   parameter int N_LEDS     = 8,
   parameter int PWM_BITS   = 8,
   parameter int DECAY_DIV  = 48000,
   parameter int DECAY_STEP = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic [N_LEDS-1:0] pattern,
   output logic [N_LEDS-1:0] led_out,
   output logic              busy
);

   localparam int PRESC_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
   localparam logic [PWM_BITS-1:0] LVL_MAX    = {PWM_BITS{1'b1}};
   localparam logic [PWM_BITS-1:0] LVL_ZERO   = '0;
   localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(DECAY_DIV - 1);
   localparam logic [PWM_BITS:0]   STEP_EXT   = (PWM_BITS + 1)'(DECAY_STEP);

   logic [PWM_BITS-1:0] pwm_cnt;
   logic [PRESC_W-1:0]  presc;
   logic [PWM_BITS-1:0] level     [N_LEDS];
   logic [PWM_BITS-1:0] level_dec [N_LEDS];
   logic [PWM_BITS-1:0] duty      [N_LEDS];
   logic [N_LEDS-1:0]   led_nxt;
   logic                any_lit;
   logic                tick;

   assign tick = enable && (presc == PRESC_LAST);

   // Saturating decrement, computed one bit wider so a step larger than the
   // current level lands on zero instead of wrapping.
   always_comb begin
      for (int i = 0; i < N_LEDS; i++) begin
         level_dec[i] = LVL_ZERO;
         if ({1'b0, level[i]} > STEP_EXT) begin
            level_dec[i] = level[i] - STEP_EXT[PWM_BITS-1:0];
         end
      end
   end

`ifdef LED_FADE_GAMMA_EN
   logic [2*PWM_BITS-1:0] level_sq [N_LEDS];

   always_comb begin
      for (int i = 0; i < N_LEDS; i++) begin
         level_sq[i] = {{PWM_BITS{1'b0}}, level[i]} * {{PWM_BITS{1'b0}}, level[i]};
         duty[i]     = level_sq[i][2*PWM_BITS-1:PWM_BITS];
      end
   end
`else
   always_comb begin
      for (int i = 0; i < N_LEDS; i++) begin
         duty[i] = level[i];
      end
   end
`endif

   // MAX is forced full-on so a lit LED never shows the single off cycle
   // that a plain (cnt < duty) compare would produce at cnt == MAX.
   always_comb begin
      led_nxt = '0;
      any_lit = 1'b0;
      for (int i = 0; i < N_LEDS; i++) begin
         any_lit = any_lit | (level[i] != LVL_ZERO);
         if (enable) begin
            if (level[i] == LVL_MAX) begin
               led_nxt[i] = 1'b1;
            end else if (level[i] != LVL_ZERO) begin
               led_nxt[i] = (pwm_cnt < duty[i]);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pwm_cnt <= '0;
         presc   <= '0;
      end else if (!enable) begin
         pwm_cnt <= '0;
         presc   <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         presc   <= tick ? '0 : presc + 1'b1;
      end
   end

   // A set request is honoured even while disabled; decay only moves on tick.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N_LEDS; i++) begin
            level[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_LEDS; i++) begin
            if (pattern[i]) begin
               level[i] <= LVL_MAX;
            end else if (tick) begin
               level[i] <= level_dec[i];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         led_out <= '0;
         busy    <= 1'b0;
      end else begin
         led_out <= led_nxt;
         busy    <= any_lit;
      end
   end

endmodule

// File: tb/tb_led_fade_pwm.sv
module tb_led_fade_pwm;

   localparam int NL   = 8;
   localparam int DIV  = 4;
   localparam int STEP = 64;
   localparam int DIV2 = 400;

   logic          clk;
   logic          reset_n;
   logic          enable;
   logic [NL-1:0] pattern;
   logic [NL-1:0] led_out;
   logic          busy;

   logic          enable2;
   logic [NL-1:0] pattern2;
   logic [NL-1:0] led_out2;
   logic          busy2;

   int tests_run;
   int tests_failed;

   typedef struct packed {
      logic [NL-1:0] led;
      logic          busy;
   } exp_t;

   exp_t sb[$];

   int m_level [NL];
   int m_pwm;
   int m_presc;

   led_fade_pwm #(.N_LEDS(NL), .PWM_BITS(8), .DECAY_DIV(DIV), .DECAY_STEP(STEP)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .pattern(pattern),
      .led_out(led_out), .busy(busy)
   );

   // Slow-decay instance so a level can be held long enough to see a whole
   // PWM period at a fixed duty.
   led_fade_pwm #(.N_LEDS(NL), .PWM_BITS(8), .DECAY_DIV(DIV2), .DECAY_STEP(128)) dut2 (
      .clk(clk), .reset_n(reset_n), .enable(enable2), .pattern(pattern2),
      .led_out(led_out2), .busy(busy2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < NL; i++) m_level[i] = 0;
      m_pwm   = 0;
      m_presc = 0;
      sb.delete();
   endtask

   // Drive one cycle of stimulus, push the outputs expected after this edge,
   // advance the model, then wait until just after the edge.
   task automatic drive_cycle(input logic [NL-1:0] pat, input logic en);
      exp_t e;
      logic tick;
      int   duty;
      pattern = pat;
      enable  = en;
      tick    = en && (m_presc == DIV - 1);
      e.led   = '0;
      e.busy  = 1'b0;
      for (int i = 0; i < NL; i++) begin
`ifdef LED_FADE_GAMMA_EN
         duty = (m_level[i] * m_level[i]) >> 8;
`else
         duty = m_level[i];
`endif
         e.led[i] = en && ((m_level[i] == 255) || (m_level[i] != 0 && m_pwm < duty));
         if (m_level[i] != 0) e.busy = 1'b1;
      end
      sb.push_back(e);
      for (int i = 0; i < NL; i++) begin
         if (pat[i]) m_level[i] = 255;
         else if (tick) m_level[i] = (m_level[i] > STEP) ? m_level[i] - STEP : 0;
      end
      m_pwm   = en ? (m_pwm + 1) % 256 : 0;
      m_presc = en ? ((m_presc == DIV - 1) ? 0 : m_presc + 1) : 0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      reset_n  = 1'b0;
      enable   = 1'b1;
      pattern  = '0;
      enable2  = 1'b1;
      pattern2 = '0;
      model_reset();
      #1;
      tests_run++;
      if (led_out !== '0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_hold: led_out=%h busy=%b expected 00/0", led_out, busy);
      end
      @(posedge clk); @(posedge clk); #1;
      reset_n = 1'b1;
      for (int c = 0; c < 1000; c++) begin
         drive_cycle('0, 1'b1);
         e = sb.pop_front();
         tests_run++;
         if (led_out !== e.led || busy !== e.busy) begin
            tests_failed++;
            $display("FAIL idle c%0d: led_out=%h busy=%b expected %h/%b", c, led_out, busy, e.led, e.busy);
         end
      end
      for (int i = 0; i < NL; i++) begin
         tests_run++;
         if (dut.level[i] !== 8'd0) begin
            tests_failed++;
            $display("FAIL idle_level%0d: got %0d expected 0", i, dut.level[i]);
         end
      end
   endtask

   task automatic test_hold_on();
      exp_t e;
      for (int c = 0; c < 600; c++) begin
         drive_cycle(8'h01, 1'b1);
         e = sb.pop_front();
         tests_run++;
         if (led_out !== e.led || busy !== e.busy) begin
            tests_failed++;
            $display("FAIL hold c%0d: led_out=%h busy=%b expected %h/%b", c, led_out, busy, e.led, e.busy);
         end
         if (c >= 1) begin
            tests_run++;
            if (led_out !== 8'h01) begin
               tests_failed++;
               $display("FAIL hold_full c%0d: led_out=%h expected 01", c, led_out);
            end
         end
      end
   endtask

   task automatic test_fade();
      exp_t e;
      int   seen[$];
      int   want[5] = '{255, 191, 127, 63, 0};
      for (int c = 0; c < 30; c++) begin
         drive_cycle(8'h00, 1'b1);
         e = sb.pop_front();
         tests_run++;
         if (led_out !== e.led || busy !== e.busy || dut.level[0] !== 8'(m_level[0])) begin
            tests_failed++;
            $display("FAIL fade c%0d: led_out=%h busy=%b lvl=%0d expected %h/%b/%0d",
                     c, led_out, busy, dut.level[0], e.led, e.busy, m_level[0]);
         end
         if (seen.size() == 0 || seen[$] != int'(dut.level[0])) seen.push_back(int'(dut.level[0]));
      end
      tests_run++;
      if (seen.size() != 5) begin
         tests_failed++;
         $display("FAIL fade_steps: got %0d distinct levels expected 5", seen.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            tests_run++;
            if (seen[k] != want[k]) begin
               tests_failed++;
               $display("FAIL fade_seq%0d: got %0d expected %0d", k, seen[k], want[k]);
            end
         end
      end
   endtask

   task automatic test_set_beats_decay();
      exp_t e;
      bit   found = 0;
      drive_cycle(8'h08, 1'b1); void'(sb.pop_front());
      drive_cycle(8'h08, 1'b1); void'(sb.pop_front());
      for (int c = 0; c < 100 && !found; c++) begin
         if (m_level[3] == 63 && m_presc == DIV - 1) found = 1;
         else begin
            drive_cycle(8'h00, 1'b1);
            e = sb.pop_front();
            tests_run++;
            if (led_out !== e.led || busy !== e.busy) begin
               tests_failed++;
               $display("FAIL setdec c%0d: led_out=%h busy=%b expected %h/%b", c, led_out, busy, e.led, e.busy);
            end
         end
      end
      tests_run++;
      if (!found) begin
         tests_failed++;
         $display("FAIL setdec_timeout: level 63 on tick cycle not reached, expected within 100 cycles");
      end else begin
         drive_cycle(8'h08, 1'b1);
         void'(sb.pop_front());
         if (dut.level[3] !== 8'd255) begin
            tests_failed++;
            $display("FAIL setdec_level: got %0d expected 255", dut.level[3]);
         end
      end
      for (int c = 0; c < 40; c++) begin
         drive_cycle(8'h00, 1'b1);
         void'(sb.pop_front());
      end
   endtask

   task automatic test_enable_freeze();
      exp_t e;
      bit   found = 0;
      drive_cycle(8'h04, 1'b1); void'(sb.pop_front());
      for (int c = 0; c < 100 && !found; c++) begin
         drive_cycle(8'h00, 1'b1);
         void'(sb.pop_front());
         if (m_level[2] == 127) found = 1;
      end
      tests_run++;
      if (!found) begin
         tests_failed++;
         $display("FAIL freeze_timeout: level 127 not reached, expected within 100 cycles");
      end
      for (int c = 0; c < 50; c++) begin
         drive_cycle(8'h00, 1'b0);
         e = sb.pop_front();
         tests_run++;
         if (led_out !== e.led || busy !== e.busy) begin
            tests_failed++;
            $display("FAIL freeze c%0d: led_out=%h busy=%b expected %h/%b", c, led_out, busy, e.led, e.busy);
         end
      end
      tests_run++;
      if (dut.level[2] !== 8'd127) begin
         tests_failed++;
         $display("FAIL freeze_level: got %0d expected 127", dut.level[2]);
      end
      drive_cycle(8'h00, 1'b1);
      void'(sb.pop_front());
      tests_run++;
      if (dut.pwm_cnt !== 8'd1 || dut.presc !== 2'd1) begin
         tests_failed++;
         $display("FAIL restart: pwm_cnt=%0d presc=%0d expected 1/1", dut.pwm_cnt, dut.presc);
      end
      for (int c = 0; c < 20; c++) begin
         drive_cycle(8'h00, 1'b1);
         e = sb.pop_front();
         tests_run++;
         if (led_out !== e.led || busy !== e.busy || dut.level[2] !== 8'(m_level[2])) begin
            tests_failed++;
            $display("FAIL resume c%0d: led_out=%h busy=%b lvl=%0d expected %h/%b/%0d",
                     c, led_out, busy, dut.level[2], e.led, e.busy, m_level[2]);
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t          e;
      logic [NL-1:0] pat;
      for (int c = 0; c < 400; c++) begin
         pat = ($urandom_range(0, 3) == 0) ? NL'($urandom) : '0;
         drive_cycle(pat, ($urandom_range(0, 15) != 0));
         e = sb.pop_front();
         tests_run++;
         if (led_out !== e.led || busy !== e.busy) begin
            tests_failed++;
            $display("FAIL b2b c%0d: led_out=%h busy=%b expected %h/%b", c, led_out, busy, e.led, e.busy);
         end
      end
   endtask

   task automatic test_reset_midfade();
      exp_t e;
      bit   found = 0;
      drive_cycle(8'h20, 1'b1); void'(sb.pop_front());
      for (int c = 0; c < 100 && !found; c++) begin
         drive_cycle(8'h00, 1'b1);
         void'(sb.pop_front());
         if (m_level[5] == 191) found = 1;
      end
      tests_run++;
      if (!found || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL rstmid_setup: found=%0d busy=%b expected 1/1", found, busy);
      end
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      tests_run++;
      if (led_out !== '0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL rstmid_async: led_out=%h busy=%b expected 00/0", led_out, busy);
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      tests_run++;
      if (led_out !== '0 || dut.level[5] !== 8'd0) begin
         tests_failed++;
         $display("FAIL rstmid_release: led_out=%h lvl=%0d expected 00/0", led_out, dut.level[5]);
      end
      drive_cycle(8'h00, 1'b1);
      e = sb.pop_front();
      tests_run++;
      if (led_out !== e.led || busy !== e.busy) begin
         tests_failed++;
         $display("FAIL rstmid_first: led_out=%h busy=%b expected %h/%b", led_out, busy, e.led, e.busy);
      end
   endtask

   task automatic test_duty_window();
      int hi = 0;
      int want;
`ifdef LED_FADE_GAMMA_EN
      want = 63;
`else
      want = 127;
`endif
      enable2  = 1'b0;
      pattern2 = '0;
      drive_cycle(8'h00, 1'b1); void'(sb.pop_front());
      enable2  = 1'b1;
      pattern2 = 8'h01;
      drive_cycle(8'h00, 1'b1); void'(sb.pop_front());
      pattern2 = '0;
      for (int c = 0; c < 500; c++) begin
         drive_cycle(8'h00, 1'b1);
         void'(sb.pop_front());
      end
      for (int c = 0; c < 256; c++) begin
         drive_cycle(8'h00, 1'b1);
         void'(sb.pop_front());
         if (led_out2[0]) hi++;
      end
      tests_run++;
      if (hi != want || busy2 !== 1'b1) begin
         tests_failed++;
         $display("FAIL duty_window: high=%0d busy=%b expected %0d/1", hi, busy2, want);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_hold_on();
      test_fade();
      test_set_beats_decay();
      test_enable_freeze();
      test_back_to_back();
      test_reset_midfade();
      test_duty_window();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
